// File: rtl/multiple_seq_ctrl_pkg.sv
// Shared definitions for the Thumb LDM/STM/PUSH/POP sequencer: opcodes,
// FSM states, special register numbers and the popcount helper.
package multiple_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_STM  = 2'b00,
    OP_LDM  = 2'b01,
    OP_PUSH = 2'b10,
    OP_POP  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_XFER = 2'b01,
    ST_WB   = 2'b10
  } state_e;

  localparam logic [3:0] REG_SP = 4'd13;
  localparam logic [3:0] REG_LR = 4'd14;
  localparam logic [3:0] REG_PC = 4'd15;

  // Register lists up to 16 bits wide are counted here.
  function automatic logic [4:0] bit_count(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) begin
      n = n + {4'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/multiple_seq_ctrl_lsb_pick.sv
// Lowest-set-bit encoder: index of the lowest set list bit plus a one-hot
// mask of that bit for clearing it.
module lsb_pick #(
  parameter int LIST_W = 9,
  parameter int IDX_W  = $clog2(LIST_W)
) (
  input  logic [LIST_W-1:0] list,
  output logic [IDX_W-1:0]  idx,
  output logic [LIST_W-1:0] clr_mask
);

  always_comb begin
    clr_mask = list & (~list + LIST_W'(1));
    idx      = '0;
    for (int i = LIST_W - 1; i >= 0; i--) begin
      if (list[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/multiple_seq_ctrl.sv
// Decode-stage sequencer for Thumb LDM/STM/PUSH/POP: one transfer per accepted
// cycle (lowest register first), then a single base-register writeback.
module multiple_seq_ctrl
  import multiple_seq_ctrl_pkg::*;
#(
  parameter int LIST_W = 9,
  parameter int AW     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [LIST_W-1:0] reglist,
  input  logic [3:0]        rn_addr,
  input  logic [AW-1:0]     base,
  input  logic              mem_ready,
  output logic              busy,
  output logic              stall,
  output logic [3:0]        reg_addr,
  output logic [AW-1:0]     mem_addr,
  output logic              w_mem_en,
  output logic              w_reg_en,
  output logic              wb_en,
  output logic [3:0]        wb_addr,
  output logic [AW-1:0]     wb_data,
  output logic              done
);

  localparam int IDX_W = $clog2(LIST_W);

  state_e              state, state_n;
  op_e                 op_q;
  logic [3:0]          rn_q;
  logic [LIST_W-1:0]   list_q;
  logic [AW-1:0]       addr_q;
  logic [AW-1:0]       final_q;
  logic                wb_ok_q;

  logic [LIST_W-1:0]   list_in;
  logic [4:0]          cnt_in;
  logic [AW-1:0]       step_in;
  logic [AW-1:0]       first_in;
  logic [AW-1:0]       final_in;
  logic                wb_ok_in;

  logic [IDX_W-1:0]    pick_idx;
  logic [LIST_W-1:0]   pick_mask;
  logic                accept;

  lsb_pick #(.LIST_W(LIST_W), .IDX_W(IDX_W)) u_lsb_pick (
    .list     (list_q),
    .idx      (pick_idx),
    .clr_mask (pick_mask)
  );

  // Start-time setup: effective list, transfer count, first and final address
  always_comb begin
    list_in = reglist;
    if (op_e'(op) == OP_STM || op_e'(op) == OP_LDM) list_in[LIST_W-1] = 1'b0;
    cnt_in   = bit_count(16'(list_in));
    step_in  = AW'(cnt_in) << 2;
    first_in = (op_e'(op) == OP_PUSH) ? base - step_in : base;
    final_in = (op_e'(op) == OP_PUSH) ? base - step_in : base + step_in;
    // Loading the base register itself means its loaded value wins over writeback
    wb_ok_in = (list_in != '0) &&
               !(op_e'(op) == OP_LDM && rn_addr < 4'd8 && list_in[rn_addr[2:0]]);
  end

  assign accept = (state == ST_XFER) && (list_q != '0) && mem_ready;

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE: if (start) state_n = ST_XFER;
      ST_XFER: begin
        if (list_q == '0) state_n = ST_WB;
        else if (mem_ready && (list_q & ~pick_mask) == '0) state_n = ST_WB;
      end
      ST_WB:   state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      busy  <= (state_n != ST_IDLE);
    end
  end

  // Operand registers carry no reset; every output is gated by the state
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && start) begin
      op_q    <= op_e'(op);
      rn_q    <= rn_addr;
      list_q  <= list_in;
      addr_q  <= first_in;
      final_q <= final_in;
      wb_ok_q <= wb_ok_in;
    end else if (accept) begin
      list_q <= list_q & ~pick_mask;
      addr_q <= addr_q + AW'(4);
    end
  end

  always_comb begin
    reg_addr = '0;
    mem_addr = '0;
    w_mem_en = 1'b0;
    w_reg_en = 1'b0;
    wb_en    = 1'b0;
    wb_addr  = '0;
    wb_data  = '0;
    done     = 1'b0;
    if (state == ST_XFER && list_q != '0) begin
      if (int'(pick_idx) >= 8) reg_addr = (op_q == OP_PUSH) ? REG_LR : REG_PC;
      else                     reg_addr = 4'(pick_idx);
      mem_addr = addr_q;
      w_mem_en = (op_q == OP_STM) || (op_q == OP_PUSH);
      w_reg_en = (op_q == OP_LDM) || (op_q == OP_POP);
    end else if (state == ST_WB) begin
      wb_en   = wb_ok_q;
      wb_addr = rn_q;
      wb_data = final_q;
      done    = 1'b1;
    end
  end

  assign stall = start | busy;

endmodule

// File: tb/tb_multiple_seq_ctrl.sv
// Scoreboard bench for multiple_seq_ctrl: directed cases plus randomized
// operations against a list-walking reference model.
module tb_multiple_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [8:0]  reglist;
  logic [3:0]  rn_addr;
  logic [31:0] base;
  logic        mem_ready;
  logic        busy, stall, w_mem_en, w_reg_en, wb_en, done;
  logic [3:0]  reg_addr, wb_addr;
  logic [31:0] mem_addr, wb_data;

  multiple_seq_ctrl #(.LIST_W(9), .AW(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .reglist(reglist),
    .rn_addr(rn_addr), .base(base), .mem_ready(mem_ready),
    .busy(busy), .stall(stall), .reg_addr(reg_addr), .mem_addr(mem_addr),
    .w_mem_en(w_mem_en), .w_reg_en(w_reg_en), .wb_en(wb_en),
    .wb_addr(wb_addr), .wb_data(wb_data), .done(done)
  );

  typedef struct packed {
    logic        is_wb;
    logic        st;
    logic        wben;
    logic [3:0]  r;
    logic [31:0] a;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted transfer and every done pulse
  logic        prev_stall = 1'b0;
  logic [37:0] prev_out;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("hold", {26'd0, reg_addr, mem_addr, w_mem_en, w_reg_en}, {26'd0, prev_out});
      if ((w_mem_en || w_reg_en) && mem_ready) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL xfer_unexpected: reg %0d addr 0x%0h", reg_addr, mem_addr);
        end else begin
          e = q.pop_front();
          check("xfer_kind", {63'd0, e.is_wb}, 64'd0);
          check("xfer", {w_mem_en, w_reg_en, reg_addr, mem_addr},
                {e.st, ~e.st, e.r, e.a});
        end
      end
      if (done) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL wb_unexpected: wb_addr %0d wb_data 0x%0h", wb_addr, wb_data);
        end else begin
          e = q.pop_front();
          check("wb_kind", {63'd0, e.is_wb}, 64'd1);
          check("wb", {wb_en, wb_addr, wb_data}, {e.wben, e.r, e.a});
        end
      end
      prev_stall = (w_mem_en || w_reg_en) && !mem_ready;
      prev_out   = {reg_addr, mem_addr, w_mem_en, w_reg_en};
    end
  end

  // Reference model: walk the list low to high, addresses rise from the lowest word
  function automatic int build_expect(input logic [1:0] o, input logic [8:0] lst,
                                      input logic [3:0] rn, input logic [31:0] b);
    logic [8:0]  eff;
    int          n, k;
    logic [31:0] first, fin;
    exp_t        e;
    eff = lst;
    if (o == 2'b00 || o == 2'b01) eff[8] = 1'b0;
    n = $countones(eff);
    first = (o == 2'b10) ? b - 32'(4 * n) : b;
    fin   = (o == 2'b10) ? b - 32'(4 * n) : b + 32'(4 * n);
    k = 0;
    for (int i = 0; i < 9; i++) begin
      if (eff[i]) begin
        e.is_wb = 1'b0;
        e.st    = (o == 2'b00 || o == 2'b10);
        e.wben  = 1'b0;
        e.r     = (i == 8) ? ((o == 2'b10) ? 4'd14 : 4'd15) : 4'(i);
        e.a     = first + 32'(4 * k);
        k++;
        q.push_back(e);
      end
    end
    e.is_wb = 1'b1;
    e.st    = 1'b0;
    e.wben  = (n != 0) && !(o == 2'b01 && rn < 4'd8 && eff[rn[2:0]]);
    e.r     = rn;
    e.a     = fin;
    q.push_back(e);
    return n;
  endfunction

  // mode 0: ready always high; 1: random; 2: low on cycles 1-2 then high
  task automatic run_op(input logic [1:0] o, input logic [8:0] lst, input logic [3:0] rn,
                        input logic [31:0] b, input int mode, input bit poke);
    int  n, rem, exp_done, c;
    bit  rdy, finished;
    n = build_expect(o, lst, rn, b);
    @(posedge clk); #1;
    start = 1'b1; op = o; reglist = lst; rn_addr = rn; base = b; mem_ready = 1'b0;
    @(negedge clk);
    check("stall_on_start", {62'd0, stall, busy}, 64'd2);
    @(posedge clk); #1;
    start = 1'b0;
    rem = n;
    exp_done = (n == 0) ? 2 : -1;
    finished = 1'b0;
    for (c = 1; c <= 200 && !finished; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ($urandom_range(0, 3) != 0);
        default: rdy = (c > 2);
      endcase
      mem_ready = rdy;
      start = poke && (c == 2);
      if (start) begin
        op = 2'($urandom); reglist = 9'($urandom); base = $urandom;
      end
      if (rem > 0 && rdy) begin
        rem--;
        if (rem == 0) exp_done = c + 1;
      end
      @(negedge clk);
      check("done_timing", {62'd0, done, busy}, {62'd0, (c == exp_done), 1'b1});
      if (done || (exp_done > 0 && c >= exp_done)) finished = 1'b1;
    end
    if (!finished) begin
      checks++; errors++;
      $display("FAIL done_timeout: no done within budget, expected cycle %0d", exp_done);
      q.delete();
    end
    @(posedge clk); #1;
    start = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    check("idle_after", {62'd0, busy, done}, 64'd0);
  endtask

  initial begin
    int n;
    logic [1:0]  ro;
    logic [8:0]  rl;
    logic [3:0]  rr;
    logic [31:0] rb;
    rst = 1'b0; start = 1'b0; op = '0; reglist = '0; rn_addr = '0; base = '0; mem_ready = 1'b0;
    #3;
    check("rst_ctrl", {54'd0, busy, stall, w_mem_en, w_reg_en, wb_en, done, reg_addr, wb_addr}, 64'd0);
    check("rst_data", {mem_addr, wb_data}, 64'd0);
    #20 rst = 1'b1;

    run_op(2'b10, 9'b1_0001_0001, 4'd13, 32'h100, 0, 1'b0); // PUSH {r0,r4,LR}
    run_op(2'b11, 9'b1_0000_0010, 4'd13, 32'h200, 0, 1'b0); // POP {r1,PC}
    run_op(2'b01, 9'b0_0000_0110, 4'd2,  32'h40,  0, 1'b0); // LDM r2!,{r1,r2}
    run_op(2'b00, 9'b0_0000_1000, 4'd5,  32'h300, 2, 1'b0); // STM {r3}, ready late
    run_op(2'b00, 9'b0_0000_0000, 4'd5,  32'h10,  0, 1'b0); // empty list
    run_op(2'b00, 9'b1_0000_0011, 4'd7,  32'h20,  0, 1'b0); // STM ignores bit8
    run_op(2'b10, 9'b0_0000_0111, 4'd13, 32'h4,   0, 1'b0); // PUSH wraps below 0

    // Reset during the second of four transfers
    n = build_expect(2'b00, 9'h00F, 4'd1, 32'h80);
    @(posedge clk); #1;
    start = 1'b1; op = 2'b00; reglist = 9'h00F; rn_addr = 4'd1; base = 32'h80;
    @(posedge clk); #1;
    start = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    check("abort_ctrl", {54'd0, busy, stall, w_mem_en, w_reg_en, wb_en, done, reg_addr, wb_addr}, 64'd0);
    check("abort_data", {mem_addr, wb_data}, 64'd0);
    q.delete();
    repeat (2) begin
      @(negedge clk);
      check("abort_quiet", {60'd0, busy, w_mem_en, w_reg_en, done}, 64'd0);
    end
    @(posedge clk); #3;
    rst = 1'b1; mem_ready = 1'b0;
    run_op(2'b10, 9'b0_1000_0001, 4'd13, 32'h1000, 0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      ro = 2'($urandom);
      rl = ($urandom_range(0, 7) == 0) ? 9'd0 : 9'($urandom);
      rr = (ro[1]) ? 4'd13 : 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0:       rb = 32'($urandom_range(0, 16)) << 2;
        1:       rb = 32'hFFFF_FFF0 + (32'($urandom_range(0, 3)) << 2);
        default: rb = $urandom & 32'hFFFF_FFFC;
      endcase
      run_op(ro, rl, rr, rb, 1, ($urandom_range(0, 1) == 1));
    end

    repeat (2) @(posedge clk);
    check("queue_empty", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
